regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port ARM-style register file for the pipelined core. It has three read ports and two write ports:
- Port A carries ALU or load results.
- Port B carries base-register writeback for pre/post-indexed LDR/STR.
- R15 is not stored. Reads of R15 return the supplied PC plus a pipeline offset.
- A per-register busy scoreboard lets the hazard unit stall on pending loads.
- Writes can optionally forward to reads in the same cycle.

Parameters:
- DATA_W, 32, register width in bits.
- NREGS, 16, architectural register count including the PC slot. Physically stored: NREGS-1.
- ADDR_W, 4, register address width. Must satisfy 2**ADDR_W >= NREGS.
- PC_OFFSET, 8, value added to pc_in when reading R15. Unsigned, DATA_W wide.

Ports:
- clk      in   1        rising-edge clock
- reset    in   1        asynchronous, active-high reset
- pc_in    in   DATA_W   current fetch PC
- ra1      in   ADDR_W   read address, port 1
- ra2      in   ADDR_W   read address, port 2
- ra3      in   ADDR_W   read address, port 3 (store data / shift register)
- rd1      out  DATA_W   read data, port 1
- rd2      out  DATA_W   read data, port 2
- rd3      out  DATA_W   read data, port 3
- wea      in   1        write enable, port A
- waa      in   ADDR_W   write address, port A
- wda      in   DATA_W   write data, port A
- web      in   1        write enable, port B (base writeback)
- wab      in   ADDR_W   write address, port B
- wdb      in   DATA_W   write data, port B
- busy_set in   1        mark register busy (load issued)
- busy_wa  in   ADDR_W   register to mark busy
- busy_clr in   1        clear busy (load data returned)
- busy_ca  in   ADDR_W   register to clear
- busy     out  NREGS    busy vector; bit NREGS-1 (PC) is always 0
- hz1      out  1        ra1 targets a busy register
- hz2      out  1        ra2 targets a busy register
- hz3      out  1        ra3 targets a busy register

Behaviour:
- Reset (async, active-high): all stored registers become 0 and busy becomes 0 immediately. Consequently rd1..rd3 read 0 for non-PC addresses and hz1..hz3 read 0. Reset asserted mid-write takes precedence; the write is lost.
- Reads are combinational, zero latency:
  - Address NREGS-1 (R15) returns pc_in + PC_OFFSET, modulo 2**DATA_W.
  - Address >= NREGS returns 0.
  - Otherwise the stored value is returned.
- Writes commit on the rising clk edge when the enable is high and the address is < NREGS-1.
  - Writes to R15 or to out-of-range addresses are silently dropped.
  - PC writes are handled by the fetch stage.
- Same-address collision: if wea && web && waa==wab, port A wins and wdb is discarded.
- Scoreboard, per register r < NREGS-1, on each clk edge:
  - busy_set && busy_wa==r sets bit r.
  - Else busy_clr && busy_ca==r clears bit r.
  - Set and clear of the same register in the same cycle: set wins, because a new producer is pending.
  - busy_set/busy_clr addressing R15 or out-of-range addresses are ignored.
- Writes do not affect busy. Only busy_clr clears a bit.
- hzN = busy[raN] when raN < NREGS-1, else 0. Combinational.
- No state machine beyond per-register busy flops. All outputs settle within the cycle of an address change.

Optional Feature:
Macro REGFILE_MP_BYPASS_EN.
- Defined:
  - Internal write-first forwarding: a read whose address equals an enabled same-cycle write address (excluding R15 and out-of-range) returns that write data. Port A has priority over port B, matching the commit rule.
  - hzN is also forced to 0 when busy_clr && busy_ca==raN in the same cycle, because the returning data is forwarded.
- Undefined:
  - Reads return the pre-edge stored value, i.e. write-then-read needs one cycle.
  - hzN reflects the registered busy bit only.

Test Plan:
- Reset: write R3=0xDEADBEEF, pulse reset asynchronously mid-cycle -> rd1 with ra1=3 reads 0 immediately; busy==0.
- PC read: pc_in=0x100, ra2=15 -> rd2=0x108. pc_in=0xFFFFFFFC, ra2=15 -> rd2=0x00000004 (wrap).
- Dual write and collision:
  - wea waa=1 wda=0x11 and web wab=2 wdb=0x22 -> next cycle R1=0x11, R2=0x22.
  - waa=wab=5 with wda=0xAA, wdb=0xBB -> R5=0xAA.
  - wea waa=15 -> no stored register changes.
- Scoreboard:
  - busy_set R4 -> busy[4]=1, hz1=1 with ra1=4.
  - busy_clr R4 -> busy[4]=0.
  - busy_set R6 and busy_clr R6 in the same cycle -> busy[6]=1.
- Bypass, macro defined: R7=0x0; wea waa=7 wda=0x55 with ra3=7 in the same cycle -> rd3=0x55 that cycle.
- Bypass, macro undefined: same stimulus -> rd3=0x0 that cycle and 0x55 the next cycle.
- Bypass, macro defined: busy[7]=1, busy_clr busy_ca=7, ra1=7 -> hz1=0 that cycle.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port ARM-style register file: 3 combinational reads, 2 writes, R15 = pc_in + PC_OFFSET, per-register busy scoreboard.
// Optional write-first forwarding with hazard suppression is enabled by defining REGFILE_MP_BYPASS_EN.
module regfile_mp #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NREGS     = 16,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned PC_OFFSET = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] ra3,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] rd3,
    input  logic              wea,
    input  logic [ADDR_W-1:0] waa,
    input  logic [DATA_W-1:0] wda,
    input  logic              web,
    input  logic [ADDR_W-1:0] wab,
    input  logic [DATA_W-1:0] wdb,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_wa,
    input  logic              busy_clr,
    input  logic [ADDR_W-1:0] busy_ca,
    output logic [NREGS-1:0]  busy,
    output logic              hz1,
    output logic              hz2,
    output logic              hz3
);

    localparam int unsigned NSTORE = NREGS - 1;

    logic [DATA_W-1:0] regs_q [NSTORE];
    logic [DATA_W-1:0] regs_d [NSTORE];
    logic [NSTORE-1:0] busy_q;
    logic [NSTORE-1:0] busy_d;

    logic [ADDR_W-1:0] ra_v [3];
    logic [DATA_W-1:0] rd_v [3];
    logic [2:0]        hz_v;
    logic [DATA_W-1:0] pc_rd;

    // Out-of-range and R15 addresses never match any stored index, so those writes drop out naturally.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NSTORE; r++) begin
            regs_d[r] = regs_q[r];
            if (wea && waa == ADDR_W'(r)) begin
                regs_d[r] = wda;
            end else if (web && wab == ADDR_W'(r)) begin
                regs_d[r] = wdb;
            end
            if (busy_set && busy_wa == ADDR_W'(r)) begin
                busy_d[r] = 1'b1;
            end else if (busy_clr && busy_ca == ADDR_W'(r)) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NSTORE; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign pc_rd   = pc_in + DATA_W'(PC_OFFSET);
    assign ra_v[0] = ra1;
    assign ra_v[1] = ra2;
    assign ra_v[2] = ra3;

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rd_v[p] = '0;
            hz_v[p] = 1'b0;
            if (32'(ra_v[p]) == NREGS - 1) begin
                rd_v[p] = pc_rd;
            end else if (32'(ra_v[p]) < NSTORE) begin
                rd_v[p] = regs_q[ra_v[p]];
                hz_v[p] = busy_q[ra_v[p]];
`ifdef REGFILE_MP_BYPASS_EN
                if (wea && waa == ra_v[p]) begin
                    rd_v[p] = wda;
                end else if (web && wab == ra_v[p]) begin
                    rd_v[p] = wdb;
                end
                // Returning load data is forwarded, so the consumer need not stall.
                if (busy_clr && busy_ca == ra_v[p]) begin
                    hz_v[p] = 1'b0;
                end
`endif
            end
        end
    end

    assign rd1  = rd_v[0];
    assign rd2  = rd_v[1];
    assign rd3  = rd_v[2];
    assign hz1  = hz_v[0];
    assign hz2  = hz_v[1];
    assign hz3  = hz_v[2];
    assign busy = {1'b0, busy_q};

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic against an array-based reference model.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic [3:0]  ra1, ra2, ra3;
    logic [31:0] rd1, rd2, rd3;
    logic        wea, web;
    logic [3:0]  waa, wab;
    logic [31:0] wda, wdb;
    logic        busy_set, busy_clr;
    logic [3:0]  busy_wa, busy_ca;
    logic [15:0] busy;
    logic        hz1, hz2, hz3;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_regs [15];
    logic [14:0] m_busy;

    regfile_mp dut (
        .clk(clk), .reset(reset), .pc_in(pc_in),
        .ra1(ra1), .ra2(ra2), .ra3(ra3),
        .rd1(rd1), .rd2(rd2), .rd3(rd3),
        .wea(wea), .waa(waa), .wda(wda),
        .web(web), .wab(wab), .wdb(wdb),
        .busy_set(busy_set), .busy_wa(busy_wa),
        .busy_clr(busy_clr), .busy_ca(busy_ca),
        .busy(busy), .hz1(hz1), .hz2(hz2), .hz3(hz3)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_rd(input logic [3:0] a);
        if (a == 4'd15) return pc_in + 32'd8;
`ifdef REGFILE_MP_BYPASS_EN
        if (wea && waa != 4'd15 && waa == a) return wda;
        if (web && wab != 4'd15 && wab == a) return wdb;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_hz(input logic [3:0] a);
        if (a == 4'd15) return 1'b0;
`ifdef REGFILE_MP_BYPASS_EN
        if (busy_clr && busy_ca == a) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 15; i++) m_regs[i] = '0;
        m_busy = '0;
    endtask

    // Apply B first then A so that A wins a collision; clear first then set so that set wins.
    task automatic commit();
        if (web && wab != 4'd15) m_regs[wab] = wdb;
        if (wea && waa != 4'd15) m_regs[waa] = wda;
        if (busy_clr && busy_ca != 4'd15) m_busy[busy_ca] = 1'b0;
        if (busy_set && busy_wa != 4'd15) m_busy[busy_wa] = 1'b1;
    endtask

    task automatic cycle();
        @(posedge clk);
        commit();
        #1;
    endtask

    task automatic idle();
        wea = 0; web = 0; busy_set = 0; busy_clr = 0;
        waa = 0; wab = 0; wda = 0; wdb = 0; busy_wa = 0; busy_ca = 0;
    endtask

    task automatic test_reset();
        idle();
        wea = 1; waa = 4'd3; wda = 32'hDEADBEEF;
        busy_set = 1; busy_wa = 4'd9;
        cycle();
        idle();
        ra1 = 4'd3; ra2 = 4'd9;
        #1;
        n_cmp++; if (rd1 !== 32'hDEADBEEF) begin n_err++; $display("FAIL reset_pre_write rd1=%h exp=%h", rd1, 32'hDEADBEEF); end
        n_cmp++; if (hz2 !== 1'b1) begin n_err++; $display("FAIL reset_pre_hz2 hz2=%b exp=1", hz2); end
        wea = 1; waa = 4'd3; wda = 32'h12345678;
        #1;
        reset = 1;
        model_clear();
        #1;
        n_cmp++; if (rd1 !== 32'h0) begin n_err++; $display("FAIL reset_async_rd1 rd1=%h exp=0", rd1); end
        n_cmp++; if (busy !== 16'h0) begin n_err++; $display("FAIL reset_async_busy busy=%h exp=0", busy); end
        n_cmp++; if (hz2 !== 1'b0) begin n_err++; $display("FAIL reset_async_hz2 hz2=%b exp=0", hz2); end
        @(posedge clk);
        #1;
        idle();
        #3;
        reset = 0;
        #1;
        n_cmp++; if (rd1 !== 32'h0) begin n_err++; $display("FAIL reset_write_lost rd1=%h exp=0", rd1); end
    endtask

    task automatic test_pc_read();
        pc_in = 32'h100; ra2 = 4'd15;
        #1;
        n_cmp++; if (rd2 !== 32'h108) begin n_err++; $display("FAIL pc_read rd2=%h exp=%h", rd2, 32'h108); end
        n_cmp++; if (hz2 !== 1'b0) begin n_err++; $display("FAIL pc_hz2 hz2=%b exp=0", hz2); end
        pc_in = 32'hFFFFFFFC;
        #1;
        n_cmp++; if (rd2 !== 32'h4) begin n_err++; $display("FAIL pc_wrap rd2=%h exp=%h", rd2, 32'h4); end
    endtask

    task automatic test_dual_write();
        idle();
        wea = 1; waa = 4'd1; wda = 32'h11;
        web = 1; wab = 4'd2; wdb = 32'h22;
        cycle();
        idle();
        ra1 = 4'd1; ra2 = 4'd2;
        #1;
        n_cmp++; if (rd1 !== 32'h11) begin n_err++; $display("FAIL dual_write_a rd1=%h exp=%h", rd1, 32'h11); end
        n_cmp++; if (rd2 !== 32'h22) begin n_err++; $display("FAIL dual_write_b rd2=%h exp=%h", rd2, 32'h22); end
    endtask

    task automatic test_collision();
        idle();
        wea = 1; waa = 4'd5; wda = 32'hAA;
        web = 1; wab = 4'd5; wdb = 32'hBB;
        cycle();
        idle();
        ra3 = 4'd5;
        #1;
        n_cmp++; if (rd3 !== 32'hAA) begin n_err++; $display("FAIL collision rd3=%h exp=%h", rd3, 32'hAA); end
    endtask

    task automatic test_r15_write();
        idle();
        wea = 1; waa = 4'd15; wda = 32'hCAFEF00D;
        web = 1; wab = 4'd15; wdb = 32'h0BADBEEF;
        cycle();
        idle();
        for (int i = 0; i < 15; i++) begin
            ra1 = 4'(i);
            #1;
            n_cmp++;
            if (rd1 !== m_regs[i]) begin n_err++; $display("FAIL r15_write_reg%0d rd1=%h exp=%h", i, rd1, m_regs[i]); end
        end
    endtask

    task automatic test_scoreboard();
        idle();
        busy_set = 1; busy_wa = 4'd4;
        cycle();
        idle();
        ra1 = 4'd4;
        #1;
        n_cmp++; if (busy[4] !== 1'b1) begin n_err++; $display("FAIL sb_set busy4=%b exp=1", busy[4]); end
        n_cmp++; if (hz1 !== 1'b1) begin n_err++; $display("FAIL sb_hz1 hz1=%b exp=1", hz1); end
        busy_clr = 1; busy_ca = 4'd4;
        cycle();
        idle();
        #1;
        n_cmp++; if (busy[4] !== 1'b0) begin n_err++; $display("FAIL sb_clr busy4=%b exp=0", busy[4]); end
        busy_set = 1; busy_wa = 4'd6; busy_clr = 1; busy_ca = 4'd6;
        cycle();
        idle();
        busy_set = 1; busy_wa = 4'd15;
        cycle();
        idle();
        #1;
        n_cmp++; if (busy[6] !== 1'b1) begin n_err++; $display("FAIL sb_set_wins busy6=%b exp=1", busy[6]); end
        n_cmp++; if (busy[15] !== 1'b0) begin n_err++; $display("FAIL sb_pc_bit busy15=%b exp=0", busy[15]); end
        n_cmp++; if (busy !== {1'b0, m_busy}) begin n_err++; $display("FAIL sb_vector busy=%h exp=%h", busy, {1'b0, m_busy}); end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_now;
        logic        exp_hz_now;
        idle();
        wea = 1; waa = 4'd7; wda = 32'h0;
        cycle();
        idle();
        wea = 1; waa = 4'd7; wda = 32'h55; ra3 = 4'd7;
`ifdef REGFILE_MP_BYPASS_EN
        exp_now = 32'h55;
`else
        exp_now = 32'h0;
`endif
        #1;
        n_cmp++; if (rd3 !== exp_now) begin n_err++; $display("FAIL bypass_same_cycle rd3=%h exp=%h", rd3, exp_now); end
        cycle();
        idle();
        #1;
        n_cmp++; if (rd3 !== 32'h55) begin n_err++; $display("FAIL bypass_next_cycle rd3=%h exp=%h", rd3, 32'h55); end
        busy_set = 1; busy_wa = 4'd7;
        cycle();
        idle();
        busy_clr = 1; busy_ca = 4'd7; ra1 = 4'd7;
`ifdef REGFILE_MP_BYPASS_EN
        exp_hz_now = 1'b0;
`else
        exp_hz_now = 1'b1;
`endif
        #1;
        n_cmp++; if (hz1 !== exp_hz_now) begin n_err++; $display("FAIL bypass_hz1 hz1=%b exp=%b", hz1, exp_hz_now); end
        cycle();
        idle();
    endtask

    task automatic test_random();
        logic [31:0] e_rd [3];
        logic        e_hz [3];
        for (int it = 0; it < 400; it++) begin
            pc_in    = $urandom;
            ra1      = 4'($urandom_range(0, 15));
            ra2      = 4'($urandom_range(0, 15));
            ra3      = 4'($urandom_range(0, 15));
            wea      = 1'($urandom_range(0, 1));
            web      = 1'($urandom_range(0, 1));
            waa      = 4'($urandom_range(0, 15));
            wab      = ($urandom_range(0, 3) == 0) ? waa : 4'($urandom_range(0, 15));
            wda      = $urandom;
            wdb      = $urandom;
            busy_set = 1'($urandom_range(0, 1));
            busy_clr = 1'($urandom_range(0, 1));
            busy_wa  = 4'($urandom_range(0, 15));
            busy_ca  = ($urandom_range(0, 3) == 0) ? busy_wa : 4'($urandom_range(0, 15));
            #1;
            e_rd[0] = exp_rd(ra1); e_rd[1] = exp_rd(ra2); e_rd[2] = exp_rd(ra3);
            e_hz[0] = exp_hz(ra1); e_hz[1] = exp_hz(ra2); e_hz[2] = exp_hz(ra3);
            n_cmp++; if (rd1 !== e_rd[0]) begin n_err++; $display("FAIL rand_rd1 it=%0d ra=%0d rd1=%h exp=%h", it, ra1, rd1, e_rd[0]); end
            n_cmp++; if (rd2 !== e_rd[1]) begin n_err++; $display("FAIL rand_rd2 it=%0d ra=%0d rd2=%h exp=%h", it, ra2, rd2, e_rd[1]); end
            n_cmp++; if (rd3 !== e_rd[2]) begin n_err++; $display("FAIL rand_rd3 it=%0d ra=%0d rd3=%h exp=%h", it, ra3, rd3, e_rd[2]); end
            n_cmp++; if (hz1 !== e_hz[0]) begin n_err++; $display("FAIL rand_hz1 it=%0d hz1=%b exp=%b", it, hz1, e_hz[0]); end
            n_cmp++; if (hz2 !== e_hz[1]) begin n_err++; $display("FAIL rand_hz2 it=%0d hz2=%b exp=%b", it, hz2, e_hz[1]); end
            n_cmp++; if (hz3 !== e_hz[2]) begin n_err++; $display("FAIL rand_hz3 it=%0d hz3=%b exp=%b", it, hz3, e_hz[2]); end
            n_cmp++; if (busy !== {1'b0, m_busy}) begin n_err++; $display("FAIL rand_busy it=%0d busy=%h exp=%h", it, busy, {1'b0, m_busy}); end
            cycle();
        end
        idle();
    endtask

    initial begin
        reset = 1;
        pc_in = '0; ra1 = '0; ra2 = '0; ra3 = '0;
        idle();
        model_clear();
        #12;
        reset = 0;
        test_reset();
        test_pc_read();
        test_dual_write();
        test_collision();
        test_r15_write();
        test_scoreboard();
        test_bypass();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
